// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step/direction move controller.
// Holds the default widths, the fixed acceleration field width and the
// controller state encoding.
package step_ctrl_pkg;

  localparam int unsigned POS_W_DEF   = 16;
  localparam int unsigned PER_W_DEF   = 16;
  localparam int unsigned PULSE_W_DEF = 4;
  localparam int unsigned ACCEL_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_e;

endpackage

// File: rtl/step_ramp_gen.sv
// Step period ramp generator.
// Holds the current step period and the acceleration step count, and moves
// the period toward cruise (accelerate) or back toward the start value
// (decelerate) once per step_taken_i strobe.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          latch a new move (period, start period, accel)
//   period_i        cruise period in clocks
//   start_period_i  first-step period
//   accel_i         per-step period change, 0 disables the ramp
//   step_taken_i    one-cycle strobe: a further step is about to be issued
//   remaining_i     steps still left after that step
//   eff_period_o    current period clamped to at least 2*PULSE_W
module step_ramp_gen
  import step_ctrl_pkg::*;
#(
  parameter int unsigned POS_W   = POS_W_DEF,
  parameter int unsigned PER_W   = PER_W_DEF,
  parameter int unsigned PULSE_W = PULSE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [PER_W-1:0]   period_i,
  input  logic [PER_W-1:0]   start_period_i,
  input  logic [ACCEL_W-1:0] accel_i,
  input  logic               step_taken_i,
  input  logic [POS_W-1:0]   remaining_i,
  output logic [PER_W:0]     eff_period_o
);

  localparam logic [PER_W:0] MIN_PER = (PER_W+1)'(2 * PULSE_W);

  logic [PER_W:0]   cur_q, cur_d;
  logic [PER_W:0]   cruise_q, cruise_d;
  logic [PER_W:0]   start_q, start_d;
  logic [PER_W:0]   accel_q, accel_d;
  logic [POS_W-1:0] ramp_q, ramp_d;
  logic [POS_W:0]   ramp_p1;
  logic [PER_W:0]   inc_sat, dec_sat, ld_period, ld_start;

  always_comb begin
    ld_period = {1'b0, period_i};
    ld_start  = {1'b0, start_period_i};
    if (accel_i == '0 || ld_start < ld_period) ld_start = ld_period;

    // One extra bit of headroom: neither add nor subtract can wrap.
    inc_sat = cur_q + accel_q;
    if (inc_sat > start_q) inc_sat = start_q;
    dec_sat = ((cur_q - cruise_q) > accel_q) ? (cur_q - accel_q) : cruise_q;

    ramp_p1 = {1'b0, ramp_q} + (POS_W+1)'(1);

    cur_d    = cur_q;
    cruise_d = cruise_q;
    start_d  = start_q;
    accel_d  = accel_q;
    ramp_d   = ramp_q;

    if (load_i) begin
      cur_d    = ld_start;
      start_d  = ld_start;
      cruise_d = ld_period;
      accel_d  = (PER_W+1)'(accel_i);
      ramp_d   = '0;
    end else if (step_taken_i) begin
      // Decelerate once the steps left no longer exceed the ramp length.
      // Accelerate only while enough steps remain to mirror the extra ramp
      // step on the way down, which keeps short moves symmetric.
      if (remaining_i <= ramp_q) begin
        cur_d = inc_sat;
      end else if ({1'b0, remaining_i} > ramp_p1 && cur_q > cruise_q) begin
        cur_d  = dec_sat;
        ramp_d = ramp_p1[POS_W-1:0];
      end
    end

    eff_period_o = (cur_q < MIN_PER) ? MIN_PER : cur_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q    <= '0;
      cruise_q <= '0;
      start_q  <= '0;
      accel_q  <= '0;
      ramp_q   <= '0;
    end else begin
      cur_q    <= cur_d;
      cruise_q <= cruise_d;
      start_q  <= start_d;
      accel_q  <= accel_d;
      ramp_q   <= ramp_d;
    end
  end

endmodule

// File: rtl/step_move_controller.sv
// Step/direction move controller for a stepper driver.
// Accepts a move command (step count, direction, cruise/start period,
// acceleration), issues step pulses with an optional trapezoidal/triangular
// speed ramp, tracks a signed position and signals completion.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake, ready only in idle
//   cmd_steps, cmd_dir         step count (0 = no-op), 1 = forward
//   cmd_period                 cruise step period in clocks
//   cmd_start_period           first-step period for the ramp
//   cmd_accel                  per-step period change, 0 = no ramp
//   abort                      finish the move after the current step
//   step, dir                  stepper driver outputs
//   busy, done                 move in progress / one-cycle end pulse
//   position                   two's complement net step count
module step_move_controller
  import step_ctrl_pkg::*;
#(
  parameter int unsigned POS_W   = POS_W_DEF,
  parameter int unsigned PER_W   = PER_W_DEF,
  parameter int unsigned PULSE_W = PULSE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [POS_W-1:0]   cmd_steps,
  input  logic               cmd_dir,
  input  logic [PER_W-1:0]   cmd_period,
  input  logic [PER_W-1:0]   cmd_start_period,
  input  logic [ACCEL_W-1:0] cmd_accel,
  input  logic               abort,
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic [POS_W-1:0]   position
);

  state_e           state_q;
  logic [POS_W-1:0] remaining_q;
  logic [PER_W:0]   timer_q;
  logic             abort_seen_q;
  logic             step_q, dir_q, busy_q, done_q, ready_q;
  logic [POS_W-1:0] pos_q;

  logic [PER_W:0]   eff_period;
  logic             accept, gap_end, pulse_end, stop, step_taken;
  logic [POS_W-1:0] rem_next, pos_next;

  assign accept     = (state_q == S_IDLE) && cmd_valid;
  // timer_q counts clocks since the step rising edge, so the edge-to-edge
  // spacing equals the clamped period exactly.
  assign pulse_end  = (timer_q == (PER_W+1)'(PULSE_W - 1));
  assign gap_end    = (state_q == S_GAP) && (timer_q == eff_period - (PER_W+1)'(1));
  assign stop       = (remaining_q == '0) || abort_seen_q || abort;
  assign step_taken = gap_end && !stop;
  assign rem_next   = remaining_q - POS_W'(1);
  assign pos_next   = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));

  step_ramp_gen #(
    .POS_W   (POS_W),
    .PER_W   (PER_W),
    .PULSE_W (PULSE_W)
  ) u_ramp (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_i         (accept),
    .period_i       (cmd_period),
    .start_period_i (cmd_start_period),
    .accel_i        (cmd_accel),
    .step_taken_i   (step_taken),
    .remaining_i    (rem_next),
    .eff_period_o   (eff_period)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      timer_q      <= '0;
      abort_seen_q <= 1'b0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
      pos_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            dir_q        <= cmd_dir;
            remaining_q  <= cmd_steps;
            abort_seen_q <= 1'b0;
            busy_q       <= 1'b1;
            ready_q      <= 1'b0;
            if (cmd_steps == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (abort) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= S_PULSE;
            step_q      <= 1'b1;
            pos_q       <= pos_next;
            remaining_q <= rem_next;
            timer_q     <= '0;
          end
        end
        S_PULSE: begin
          timer_q      <= timer_q + (PER_W+1)'(1);
          abort_seen_q <= abort_seen_q | abort;
          if (pulse_end) begin
            state_q <= S_GAP;
            step_q  <= 1'b0;
          end
        end
        S_GAP: begin
          timer_q      <= timer_q + (PER_W+1)'(1);
          abort_seen_q <= abort_seen_q | abort;
          if (gap_end) begin
            if (stop) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_PULSE;
              step_q       <= 1'b1;
              pos_q        <= pos_next;
              remaining_q  <= rem_next;
              timer_q      <= '0;
              abort_seen_q <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign step      = step_q;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign position  = pos_q;

endmodule

// File: doc/step_move_controller.md
STEP_MOVE_CONTROLLER -- requirements
Module: step_move_controller

Interface
REQ-001 Parameter POS_W, default 16: width of position and step count.
REQ-002 Parameter PER_W, default 16: width of period fields, in clocks.
REQ-003 Parameter PULSE_W, default 4: step high time in clocks.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  move command offered.
REQ-007 cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_steps  in  POS_W  unsigned step count; 0 = no-op move.
REQ-009 cmd_dir  in  1  1 = forward (position increments), 0 = reverse.
REQ-010 cmd_period  in  PER_W  cruise period, step rising edge to next step rising edge.
REQ-011 cmd_start_period  in  PER_W  first-step period for the ramp.
REQ-012 cmd_accel  in  8  per-step period change; 0 = no ramp.
REQ-013 abort  in  1  level; end the move after the current step completes.
REQ-014 step  out  1  step pulse to the stepper driver.
REQ-015 dir  out  1  direction to the stepper driver.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at move end, including no-op and aborted moves.
REQ-018 position  out  POS_W  signed net step count, two's complement.

Function
REQ-019 States: IDLE, SETUP, PULSE, GAP, DONE; all outputs registered.
REQ-020 IDLE->SETUP on accept with cmd_steps>0. Accept latches all cmd_* fields and loads dir from cmd_dir.
REQ-021 IDLE->DONE on accept with cmd_steps==0; no step is issued.
REQ-022 SETUP lasts 1 cycle, giving 1 cycle of dir setup before the first step. SETUP->PULSE, or SETUP->DONE if abort is high.
REQ-023 PULSE: step=1 for exactly PULSE_W cycles. Position changes by ±1 in the first PULSE cycle; remaining count decrements by 1 at the same time.
REQ-024 GAP: step=0 for cur_period-PULSE_W cycles. At GAP end the block goes to DONE if remaining==0 or abort was seen during this step; otherwise it goes to PULSE.
REQ-025 Effective cur_period is clamped to at least 2*PULSE_W; step-edge-to-step-edge spacing equals the clamped value exactly.
REQ-026 cmd_accel==0: cur_period = cmd_period for every step.
REQ-027 cmd_accel>0:
- Start value: cur_period starts at max(cmd_start_period, cmd_period).
- Acceleration: after each step, while accelerating, cur_period -= cmd_accel, saturating at cmd_period, and ramp_cnt increments.
- Deceleration: once remaining <= ramp_cnt, each step adds cmd_accel, saturating at the start value.
- Acceleration ends at cruise or when remaining <= ramp_cnt, whichever comes first. A short move therefore gives a symmetric triangle profile.
REQ-028 Ramp arithmetic uses PER_W+1 bits internally; no wrap on add or subtract.
REQ-029 DONE lasts 1 cycle with done=1, then goes to IDLE. dir holds its value until the next accept.
REQ-030 position wraps modulo 2^POS_W without a flag.
REQ-031 abort in IDLE or DONE is ignored. abort in PULSE/GAP never truncates the pulse or gap in progress.
REQ-032 cmd_* inputs are ignored while busy, and cmd_ready=0 during DONE.

Reset
REQ-033 On rst_n low:
- state goes to IDLE;
- step=0, dir=0, busy=0, done=0, position=0;
- cmd_ready=1 after release;
- counters and latched fields are cleared.
REQ-034 Reset mid-move takes effect immediately, cutting the step pulse asynchronously. No done pulse is generated.

Structure
REQ-035 Package step_ctrl_pkg holds the state enum, the default PULSE_W/POS_W/PER_W constants, and the accel width (8).
REQ-036 Sub-module step_ramp_gen holds cur_period, ramp_cnt, and the accel/decel/saturation logic. It is advanced by a one-cycle "step_taken" strobe from the FSM.

Verification
REQ-037 Constant speed: steps=5, dir=1, period=10, accel=0.
- Expected: 5 pulses, each 4 cycles high, rising edges 10 cycles apart.
- First step 1 cycle after SETUP; done 1 cycle after the last gap; position=5.
REQ-038 Ramp: steps=8, start=40, period=20, accel=10. Expected edge spacing 40,30,20,20,20,30,40; position=8.
REQ-039 Triangle: steps=3, start=40, period=10, accel=10. Expected spacing 40,40; ramp peak is never reached.
REQ-040 Reverse then no-op:
- Reverse: steps=3 with dir=0 from position 0 gives position=-3.
- No-op: steps=0 gives done 1 cycle after accept with no step edge.
REQ-041 Abort: abort asserted mid-gap of step 2 of 10. Expected: gap completes, no step 3, done pulses, position=2.
REQ-042 Reset: rst_n low during a PULSE. Expected: step=0 and position=0 immediately; cmd_ready=1 after release.
